// File: rtl/riscv_fetch_pkg.sv
// Shared front-end types: RV32I base opcodes, fetch buffer entry and the opcode legality check.
package riscv_fetch_pkg;

  typedef enum logic [6:0] {
    op_load  = 7'b0000011,
    op_imm   = 7'b0010011,
    op_store = 7'b0100011,
    op_reg   = 7'b0110011,
    op_br    = 7'b1100011
  } riscvi_opcode_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      op_load, op_imm, op_store, op_reg, op_br: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Fetch-stage bundle: imem request/response, branch redirect and the decode hand-off.
interface riscv_fetch_if #(
  parameter int XLEN = 32
);
  import riscv_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [31:0]     dec_instr;
  riscvi_opcode_t  dec_opcode;
  logic            dec_illegal;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, dec_opcode, dec_illegal,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, dec_opcode, dec_illegal,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// Fetch buffer: registered FIFO with async reset and synchronous flush (flush beats push).
// Pushed data reaches the head the following cycle; when empty the head holds the last popped entry.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           push_dat_i,
  input  logic                       pop_i,
  output logic                       vld_o,
  output T                           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  T              last_q;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign vld_o   = (count_q != '0);
  assign do_pop  = pop_i && vld_o;
  assign head_o  = vld_o ? mem_q[rd_q] : last_q;
  assign count_o = count_q;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (do_pop) rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (do_pop) last_q <= mem_q[rd_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/riscv_fetch.sv
// RV32I fetch stage: issues word fetches, tracks in-flight PCs in order and buffers responses for decode.
// A redirect flushes the buffer and marks every outstanding request so its response is dropped.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int              FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  riscv_fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d, kill_q, kill_d, fifo_count;
  logic [AW-1:0]   iss_ptr_q, ret_ptr_q;
  logic [XLEN-1:0] inflight_pc_q [FIFO_DEPTH];
  logic            ill_hold_q;
  logic            has_room, req_vld, req_fire, rsp_vld, rsp_drop, push, pop, fifo_vld;
  fetch_entry_t    push_dat, head;

  // Every in-flight request owns a buffer slot, so issue stops once the slots are spoken for.
  assign has_room = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign req_vld  = !rst && !bus.redirect_valid && has_room;
  assign req_fire = req_vld && bus.imem_req_ready;
  assign rsp_vld  = bus.imem_rsp_valid;
  assign rsp_drop = rsp_vld && (kill_q != '0 || bus.redirect_valid);
  assign push     = rsp_vld && !rsp_drop;
  assign pop      = fifo_vld && bus.dec_ready;
  assign push_dat = '{pc: 32'(inflight_pc_q[ret_ptr_q]), instr: bus.imem_rsp_data};

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.redirect_valid),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .vld_o      (fifo_vld),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  always_comb begin
    pc_d    = pc_q;
    kill_d  = kill_q;
    outst_d = outst_q + CW'(req_fire) - CW'(rsp_vld);
    if (bus.redirect_valid) begin
      pc_d   = bus.redirect_pc & ~XLEN'(3);
      kill_d = outst_q - CW'(rsp_vld);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_vld && kill_q != '0) kill_d = kill_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      outst_q    <= '0;
      kill_q     <= '0;
      iss_ptr_q  <= '0;
      ret_ptr_q  <= '0;
      ill_hold_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      kill_q  <= kill_d;
      if (req_fire) iss_ptr_q <= iss_ptr_q + AW'(1);
      if (rsp_vld)  ret_ptr_q <= ret_ptr_q + AW'(1);
      if (pop)      ill_hold_q <= !is_legal_opcode(head.instr[6:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) inflight_pc_q[iss_ptr_q] <= pc_q;
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = fifo_vld;
  assign bus.dec_pc         = XLEN'(head.pc);
  assign bus.dec_instr      = head.instr;
  assign bus.dec_opcode     = riscvi_opcode_t'(head.instr[6:0]);
  assign bus.dec_illegal    = fifo_vld ? !is_legal_opcode(head.instr[6:0]) : ill_hold_q;

  rsp_needs_outstanding_a: assert property (@(posedge clk) disable iff (rst)
    !(rsp_vld && outst_q == '0));

endmodule

// File: tb/tb_riscv_fetch.sv
// Fetch stage bench: in-order imem responder with variable latency, queue-based reference model.
module tb_riscv_fetch;
  import riscv_fetch_pkg::*;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_fetch_if #(.XLEN(32)) bus ();

  riscv_fetch #(
    .XLEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Memory image: 0x0 holds an op_imm word, 0x14 an illegal 0x7F word, the rest a mix of opcodes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    if (a == 32'h14) return 32'h0000_007F;
    if (a == 32'h0)  return 32'h0000_0013;
    case (a[4:2])
      3'd0:    op = 7'h13;
      3'd1:    op = 7'h33;
      3'd2:    op = 7'h03;
      3'd3:    op = 7'h23;
      3'd4:    op = 7'h63;
      3'd5:    op = 7'h7F;
      3'd6:    op = 7'h37;
      default: op = 7'h6F;
    endcase
    return {a[31:7] ^ a[26:2], op};
  endfunction

  function automatic bit model_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h13, 7'h23, 7'h33, 7'h63};
  endfunction

  // Reference model: requests in flight carry a killed flag, buffered entries are a plain queue.
  typedef struct { logic [31:0] pc; bit killed; } infl_t;
  infl_t        infl_q[$];
  fetch_entry_t buf_q[$];
  fetch_entry_t last_pop;
  logic         last_ill;
  logic [31:0]  mpc;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    lat_min = 1;
  int    lat_max = 1;
  int    cyc     = 0;

  logic        obs_fire, obs_pop, obs_dv, obs_rv, obs_ill;
  logic [31:0] obs_addr, obs_pop_pc, obs_instr;
  logic [6:0]  obs_op;

  task automatic model_reset();
    infl_q.delete();
    buf_q.delete();
    mq.delete();
    mpc      = RST_PC;
    last_pop = '0;
    last_ill = 1'b0;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b0;
    #1;
    check_eq("rst_req_valid", 64'(bus.imem_req_valid), 64'(1'b0));
    check_eq("rst_req_addr",  64'(bus.imem_req_addr),  64'(RST_PC));
    check_eq("rst_dec_valid", 64'(bus.dec_valid),      64'(1'b0));
    check_eq("rst_dec_pc",    64'(bus.dec_pc),         64'(32'h0));
    check_eq("rst_dec_instr", 64'(bus.dec_instr),      64'(32'h0));
    check_eq("rst_dec_ill",   64'(bus.dec_illegal),    64'(1'b0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc++;
  endtask

  // One cycle: drive inputs at the falling edge, compare against the model, then advance both.
  task automatic cycle(input bit rdy, input bit dready, input bit redir, input logic [31:0] rpc);
    fetch_entry_t head;
    infl_t        e;
    logic         exp_v, exp_rv, exp_ill;
    bus.imem_req_ready = rdy;
    bus.dec_ready      = dready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    exp_v   = (buf_q.size() != 0);
    head    = exp_v ? buf_q[0] : last_pop;
    exp_ill = exp_v ? !model_legal(head.instr[6:0]) : last_ill;
    exp_rv  = !redir && (infl_q.size() + buf_q.size() < DEPTH);
    check_eq("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    check_eq("req_addr",  64'(bus.imem_req_addr),  64'(mpc));
    check_eq("dec_valid", 64'(bus.dec_valid),      64'(exp_v));
    check_eq("dec_pc",    64'(bus.dec_pc),         64'(head.pc));
    check_eq("dec_instr", 64'(bus.dec_instr),      64'(head.instr));
    check_eq("dec_op",    64'(bus.dec_opcode),     64'(head.instr[6:0]));
    check_eq("dec_ill",   64'(bus.dec_illegal),    64'(exp_ill));

    obs_rv     = bus.imem_req_valid;
    obs_fire   = bus.imem_req_valid && rdy;
    obs_addr   = bus.imem_req_addr;
    obs_dv     = bus.dec_valid;
    obs_pop    = bus.dec_valid && dready;
    obs_pop_pc = bus.dec_pc;
    obs_instr  = bus.dec_instr;
    obs_op     = bus.dec_opcode;
    obs_ill    = bus.dec_illegal;

    if (bus.imem_rsp_valid) mq.delete(0);
    if (obs_fire) mq.push_back('{addr: bus.imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});

    if (exp_v && dready) begin
      last_pop = buf_q.pop_front();
      last_ill = !model_legal(last_pop.instr[6:0]);
    end
    if (bus.imem_rsp_valid && infl_q.size() > 0) begin
      e = infl_q.pop_front();
      if (!e.killed && !redir) buf_q.push_back('{pc: e.pc, instr: bus.imem_rsp_data});
    end
    if (redir) begin
      buf_q.delete();
      foreach (infl_q[i]) infl_q[i].killed = 1'b1;
      mpc = rpc & ~32'h3;
    end else if (exp_rv && rdy) begin
      infl_q.push_back('{pc: mpc, killed: 1'b0});
      mpc = mpc + 32'h4;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int  k, pops;
    bit  seen, done, redir_next;
    logic [31:0] wrap_exp [2];
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;
    @(negedge clk);
    do_reset();

    // Streaming at one instruction per cycle.
    pops = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (i < 3) begin
        check_eq("A_fire", 64'(obs_fire), 64'(1'b1));
        check_eq("A_addr", 64'(obs_addr), 64'(32'(i * 4)));
      end
      if (i >= 2) pops += int'(obs_pop);
      if (i >= 2 && i < 5) check_eq("A_pop_pc", 64'(obs_pop_pc), 64'(32'((i - 2) * 4)));
      if (i == 2) begin
        check_eq("A_imm_op",  64'(obs_op),  64'(7'h13));
        check_eq("A_imm_ill", 64'(obs_ill), 64'(1'b0));
      end
      if (i == 7) begin
        check_eq("A_7f_instr", 64'(obs_instr), 64'(32'h7F));
        check_eq("A_7f_ill",   64'(obs_ill),   64'(1'b1));
      end
    end
    check_eq("A_throughput", 64'(pops), 64'(12));

    // Decode stalled: fetch stops after DEPTH requests, then drains in order and resumes.
    do_reset();
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      k += int'(obs_fire);
    end
    check_eq("B_reqs", 64'(k), 64'(DEPTH));
    check_eq("B_stalled", 64'(obs_rv), 64'(1'b0));
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_pop && k < 4) begin
        check_eq("B_pop_pc", 64'(obs_pop_pc), 64'(32'(k * 4)));
        k++;
      end
      if (obs_fire && !seen) begin
        check_eq("B_resume", 64'(obs_addr), 64'(32'h10));
        seen = 1'b1;
      end
    end
    check_eq("B_pops", 64'(k), 64'(4));
    check_eq("B_resumed", 64'(seen), 64'(1'b1));

    // Redirect with three requests in flight under a 3-cycle memory.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (infl_q.size() == 3) begin
        cycle(1'b1, 1'b1, 1'b1, 32'h103);
        done = 1'b1;
      end else begin
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
      end
    end
    check_eq("C_redirected", 64'(done), 64'(1'b1));
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_fire && !seen) begin
        check_eq("C_first_addr", 64'(obs_addr), 64'(32'h100));
        seen = 1'b1;
      end
      if (obs_pop && k == 0) begin
        check_eq("C_first_pc", 64'(obs_pop_pc), 64'(32'h100));
        k = 1;
      end
    end
    check_eq("C_popped", 64'(k), 64'(1));

    // Redirect landing on a response and a decode handshake.
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    check_eq("D_pop", 64'(obs_pop), 64'(1'b1));
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("D_empty", 64'(obs_dv), 64'(1'b0));

    // PC wrap at the top of the address space, then reset mid-stream.
    do_reset();
    wrap_exp[0] = 32'hFFFF_FFFC;
    wrap_exp[1] = 32'h0000_0000;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_fire && k < 2) begin
        check_eq("E_wrap_addr", 64'(obs_addr), 64'(wrap_exp[k]));
        k++;
      end
    end
    check_eq("E_wrap_count", 64'(k), 64'(2));
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("E_post_rst_fire", 64'(obs_fire), 64'(1'b1));
    check_eq("E_post_rst_addr", 64'(obs_addr), 64'(RST_PC));

    // Random traffic: variable latency, stalls on both sides, redirects (sometimes back-to-back).
    do_reset();
    lat_min = 1;
    lat_max = 4;
    redir_next = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      if (i == 1500) do_reset();
      r = redir_next || ($urandom_range(0, 19) == 0);
      redir_next = r && !redir_next && ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
